// File: rtl/sdram_req_queue.sv
// Host-side request queue for the 8-bit SDRAM controller: an in-order FIFO of byte
// requests, issued one at a time, with read bytes returned on a held response port.
module sdram_req_queue #(
  parameter int HADDR_WIDTH = 25,
  parameter int FIFO_DEPTH  = 4,
  parameter int LVL_WIDTH   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [HADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]             req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [7:0]             rsp_rdata,
  output logic [LVL_WIDTH-1:0]   fifo_level,
  output logic [HADDR_WIDTH-1:0] sd_wr_addr,
  output logic [7:0]             sd_wr_data,
  output logic                   sd_wr_enable,
  output logic [HADDR_WIDTH-1:0] sd_rd_addr,
  output logic                   sd_rd_enable,
  input  logic [7:0]             sd_rd_data,
  input  logic                   sd_rd_ready,
  input  logic                   sd_ack,
  input  logic                   sd_busy
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = 1 + HADDR_WIDTH + 8;
  localparam logic [LVL_WIDTH-1:0] FULL_LVL = LVL_WIDTH'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ISSUE_WR = 3'd1;
  localparam logic [2:0] ST_ISSUE_RD = 3'd2;
  localparam logic [2:0] ST_WAIT_WR  = 3'd3;
  localparam logic [2:0] ST_WAIT_RD  = 3'd4;

  // Handshakes: a request transfers on a rising clk edge where req_valid && req_ready;
  // a response transfers where rsp_valid && rsp_ready. Valid holds its payload until then.

  logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_WIDTH-1:0]   count_q, count_d;
  logic                   req_ready_q, req_ready_d;

  logic [2:0]             state_q, state_d;
  logic [HADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic                   wr_en_q, wr_en_d;
  logic [HADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                   rd_en_q, rd_en_d;
  logic                   busy_seen_q, busy_seen_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [7:0]             rsp_rdata_q, rsp_rdata_d;

  logic                   push;
  logic                   pop;
  logic [ENTRY_W-1:0]     head;
  logic                   head_we;
  logic [HADDR_WIDTH-1:0] head_addr;
  logic [7:0]             head_data;

  assign push      = req_valid && req_ready_q;
  assign head      = mem_q[rd_ptr_q];
  assign head_we   = head[ENTRY_W-1];
  assign head_addr = head[8 +: HADDR_WIDTH];
  assign head_data = head[7:0];

  // Ready is registered from the next level, so a pop while full only reopens
  // the port on the following cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + LVL_WIDTH'(1);
      2'b01:   count_d = count_q - LVL_WIDTH'(1);
      default: count_d = count_q;
    endcase
    req_ready_d = (count_d != FULL_LVL);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_we, req_addr, req_wdata};
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = wr_en_q;
    rd_addr_d   = rd_addr_q;
    rd_en_d     = rd_en_q;
    busy_seen_d = busy_seen_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    pop         = 1'b0;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        // A pending response blocks all issue, writes included, to keep strict order.
        if ((count_q != '0) && !rsp_valid_q) begin
          pop = 1'b1;
          if (head_we) begin
            wr_addr_d = head_addr;
            wr_data_d = head_data;
            wr_en_d   = 1'b1;
            state_d   = ST_ISSUE_WR;
          end else begin
            rd_addr_d = head_addr;
            rd_en_d   = 1'b1;
            state_d   = ST_ISSUE_RD;
          end
        end
      end
      ST_ISSUE_WR: begin
        if (sd_ack) begin
          wr_en_d     = 1'b0;
          busy_seen_d = 1'b0;
          state_d     = ST_WAIT_WR;
        end
      end
      ST_ISSUE_RD: begin
        if (sd_ack) begin
          rd_en_d = 1'b0;
          state_d = ST_WAIT_RD;
        end
      end
      ST_WAIT_WR: begin
        if (sd_busy) begin
          busy_seen_d = 1'b1;
        end else if (busy_seen_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_RD: begin
        if (sd_rd_ready) begin
          rsp_rdata_d = sd_rd_data;
          rsp_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        wr_en_d = 1'b0;
        rd_en_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      req_ready_q <= 1'b1;
      state_q     <= ST_IDLE;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_en_q     <= 1'b0;
      busy_seen_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      req_ready_q <= req_ready_d;
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      rd_addr_q   <= rd_addr_d;
      rd_en_q     <= rd_en_d;
      busy_seen_q <= busy_seen_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign fifo_level   = count_q;
  assign sd_wr_addr   = wr_addr_q;
  assign sd_wr_data   = wr_data_q;
  assign sd_wr_enable = wr_en_q;
  assign sd_rd_addr   = rd_addr_q;
  assign sd_rd_enable = rd_en_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;

endmodule
